// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the single-port instruction memory between
// the fetch stage (one read per cycle) and a burst program loader.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   fetch_req/addr    fetch read request and word address
//   fetch_hold        stall to the fetch stage while the loader owns memory
//   cpu_rst_o         one-cycle restart pulse after a load completes
//   load_req          loader ownership request (level, held for the burst)
//   ld_base           first write address, sampled on grant
//   ld_valid/data     loader word and its valid
//   ld_last           final word marker (qualified by ld_valid)
//   ld_ready          arbiter accepts a loader word this cycle
//   load_busy         high whenever the arbiter is not in RUN
//   load_count        words accepted in the current/last burst
//   load_err          sticky overflow / aborted-burst flag
//   mem_*             single-port memory interface (combinational mux)
module imem_load_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_hold,
   output logic              cpu_rst_o,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              load_busy,
   output logic [ADDR_W:0]   load_count,
   output logic              load_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);

   typedef enum logic [1:0] {
      S_RUN,
      S_HOLD,
      S_LOAD,
      S_RESTART
   } state_t;

   localparam logic [ADDR_W:0] LP_TOP = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] LP_CNT_MAX = '1;

   state_t r_state;
   state_t w_next;

   // One extra bit so the pointer can sit past the top without wrapping.
   logic [ADDR_W:0] r_wptr;
   logic [ADDR_W:0] r_load_count;
   logic            r_fetch_hold;
   logic            r_cpu_rst;
   logic            r_ld_ready;
   logic            r_load_busy;
   logic            r_load_err;

   logic w_ovf;
   logic w_accept;
   logic w_write;
   logic w_abort;
   logic w_grant;

   assign w_ovf   = (r_wptr > LP_TOP);
   assign w_grant = (r_state == S_RUN) && load_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_write   = 1'b0;
      w_abort   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (r_state)
         S_RUN: begin
            mem_en   = fetch_req;
            mem_addr = fetch_addr;
            if (load_req) begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            // Read issued in the last RUN cycle retires here.
            w_next = S_LOAD;
         end
         S_LOAD: begin
            // A last word wins over a dropped load_req.
            if (ld_valid && r_ld_ready && ld_last) begin
               w_accept = 1'b1;
               w_next   = S_RESTART;
            end else if (!load_req) begin
               w_abort = 1'b1;
               w_next  = S_RESTART;
            end else if (ld_valid && r_ld_ready) begin
               w_accept = 1'b1;
            end
            w_write   = w_accept && !w_ovf;
            mem_en    = w_write;
            mem_we    = w_write;
            mem_addr  = r_wptr[ADDR_W-1:0];
            mem_wdata = ld_data;
         end
         S_RESTART: begin
            w_next = S_RUN;
         end
         default: begin
            w_next = S_RUN;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_hold <= 1'b0;
         r_cpu_rst    <= 1'b0;
         r_ld_ready   <= 1'b0;
         r_load_busy  <= 1'b0;
      end else begin
         r_fetch_hold <= (w_next != S_RUN);
         r_cpu_rst    <= (w_next == S_RESTART);
         r_ld_ready   <= (w_next == S_LOAD);
         r_load_busy  <= (w_next != S_RUN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr       <= '0;
         r_load_count <= '0;
         r_load_err   <= 1'b0;
      end else if (w_grant) begin
         r_wptr       <= {1'b0, ld_base};
         r_load_count <= '0;
         r_load_err   <= 1'b0;
      end else if (w_accept) begin
         if (r_load_count != LP_CNT_MAX) begin
            r_load_count <= r_load_count + 1'b1;
         end
         // Pointer parks past the top; later words are dropped.
         if (w_ovf) begin
            r_load_err <= 1'b1;
         end else begin
            r_wptr <= r_wptr + 1'b1;
         end
      end else if (w_abort) begin
         r_load_err <= 1'b1;
      end
   end

   assign fetch_hold = r_fetch_hold;
   assign cpu_rst_o  = r_cpu_rst;
   assign ld_ready   = r_ld_ready;
   assign load_busy  = r_load_busy;
   assign load_count = r_load_count;
   assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed self-checking bench for imem_load_arbiter.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_imem_load_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_hold;
   logic          cpu_rst_o;
   logic          load_req;
   logic [AW-1:0] ld_base;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          load_busy;
   logic [AW:0]   load_count;
   logic          load_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] tb_mem [DEPTH];
   int            wr_cnt = 0;

   imem_load_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch_req (fetch_req),
      .fetch_addr(fetch_addr),
      .fetch_hold(fetch_hold),
      .cpu_rst_o (cpu_rst_o),
      .load_req  (load_req),
      .ld_base   (ld_base),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .load_busy (load_busy),
      .load_count(load_count),
      .load_err  (load_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic grant(input logic [AW-1:0] base);
      load_req = 1'b1;
      ld_base  = base;
      nxt();
      nxt();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({fetch_hold, cpu_rst_o, ld_ready, load_busy} !== 4'b0000)
         $display("FAIL reset_flags got %b exp 0000",
                  {fetch_hold, cpu_rst_o, ld_ready, load_busy});
      else n_pass++;
      n_checks++;
      if ({load_err, load_count} !== 12'd0)
         $display("FAIL reset_cnt_err got %0d/%0b exp 0/0",
                  load_count, load_err);
      else n_pass++;
      n_checks++;
      if (mem_we !== 1'b0)
         $display("FAIL reset_we got %b exp 0", mem_we);
      else n_pass++;
      nxt();
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 3; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = AW'(5 + i);
         @(negedge clk);
         n_checks++;
         if (mem_addr !== AW'(5 + i))
            $display("FAIL fetch_addr got %0d exp %0d", mem_addr, 5 + i);
         else n_pass++;
         n_checks++;
         if ({mem_en, mem_we, fetch_hold} !== 3'b100)
            $display("FAIL fetch_ctl got %b exp 100",
                     {mem_en, mem_we, fetch_hold});
         else n_pass++;
         nxt();
      end
   endtask

   task automatic test_load_basic();
      load_req   = 1'b1;
      ld_base    = '0;
      fetch_addr = AW'(9);
      @(negedge clk);
      n_checks++;
      if ({fetch_hold, mem_en} !== 2'b01)
         $display("FAIL basic_run got %b exp 01", {fetch_hold, mem_en});
      else n_pass++;
      nxt();
      ld_base = AW'(77);
      @(negedge clk);
      n_checks++;
      if ({fetch_hold, ld_ready, mem_en, load_busy} !== 4'b1001)
         $display("FAIL basic_hold got %b exp 1001",
                  {fetch_hold, ld_ready, mem_en, load_busy});
      else n_pass++;
      nxt();
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = DW'(32'hA0 + i);
         ld_last  = (i == 3);
         @(negedge clk);
         n_checks++;
         if ({ld_ready, fetch_hold, mem_en, mem_we} !== 4'b1111)
            $display("FAIL basic_wr_ctl got %b exp 1111",
                     {ld_ready, fetch_hold, mem_en, mem_we});
         else n_pass++;
         n_checks++;
         if (mem_addr !== AW'(i) || mem_wdata !== DW'(32'hA0 + i))
            $display("FAIL basic_wr got %0d:%h exp %0d:%h",
                     mem_addr, mem_wdata, i, 32'hA0 + i);
         else n_pass++;
         nxt();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      load_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_o, fetch_hold, ld_ready, mem_en} !== 4'b1100)
         $display("FAIL basic_restart got %b exp 1100",
                  {cpu_rst_o, fetch_hold, ld_ready, mem_en});
      else n_pass++;
      n_checks++;
      if (load_count !== 11'd4 || load_err !== 1'b0)
         $display("FAIL basic_cnt got %0d/%0b exp 4/0",
                  load_count, load_err);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_o, fetch_hold, load_busy} !== 3'b000)
         $display("FAIL basic_resume got %b exp 000",
                  {cpu_rst_o, fetch_hold, load_busy});
      else n_pass++;
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== AW'(9) || load_count !== 11'd4)
         $display("FAIL basic_run2 got %b:%0d:%0d exp 1:9:4",
                  mem_en, mem_addr, load_count);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (tb_mem[i] !== DW'(32'hA0 + i))
            $display("FAIL basic_mem got %h exp %h", tb_mem[i], 32'hA0 + i);
         else n_pass++;
      end
      fetch_req = 1'b0;
      nxt();
   endtask

   task automatic test_throttle();
      int k;
      int wc0;
      k = 0;
      grant(AW'(100));
      wc0 = wr_cnt;
      for (int j = 0; j < 5; j++) begin
         ld_valid = (j % 2 == 0);
         ld_data  = DW'(32'hB0 + k);
         ld_last  = (j == 4);
         @(negedge clk);
         n_checks++;
         if (fetch_hold !== 1'b1)
            $display("FAIL thr_hold got %b exp 1", fetch_hold);
         else n_pass++;
         if (j % 2 == 0) begin
            n_checks++;
            if ({mem_en, mem_we} !== 2'b11 || mem_addr !== AW'(100 + k))
               $display("FAIL thr_wr got %b:%0d exp 11:%0d",
                        {mem_en, mem_we}, mem_addr, 100 + k);
            else n_pass++;
         end else begin
            n_checks++;
            if (mem_en !== 1'b0)
               $display("FAIL thr_idle got %b exp 0", mem_en);
            else n_pass++;
         end
         nxt();
         if (j % 2 == 0) k++;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      load_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_rst_o !== 1'b1 || load_count !== 11'd3)
         $display("FAIL thr_restart got %b:%0d exp 1:3",
                  cpu_rst_o, load_count);
      else n_pass++;
      nxt();
      n_checks++;
      if (wr_cnt - wc0 !== 3)
         $display("FAIL thr_nwr got %0d exp 3", wr_cnt - wc0);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (tb_mem[100 + i] !== DW'(32'hB0 + i))
            $display("FAIL thr_mem got %h exp %h",
                     tb_mem[100 + i], 32'hB0 + i);
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      int  wc0;
      logic exp_en;
      grant(AW'(1022));
      wc0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = DW'(32'hD0 + i);
         ld_last  = (i == 3);
         exp_en   = (i < 2);
         @(negedge clk);
         n_checks++;
         if (mem_en !== exp_en || ld_ready !== 1'b1)
            $display("FAIL ovf_en got %b:%b exp %b:1",
                     mem_en, ld_ready, exp_en);
         else n_pass++;
         if (i < 2) begin
            n_checks++;
            if (mem_addr !== AW'(1022 + i))
               $display("FAIL ovf_addr got %0d exp %0d",
                        mem_addr, 1022 + i);
            else n_pass++;
         end
         nxt();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      load_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_o, load_err} !== 2'b11 || load_count !== 11'd4)
         $display("FAIL ovf_restart got %b:%0d exp 11:4",
                  {cpu_rst_o, load_err}, load_count);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if (fetch_hold !== 1'b0 || wr_cnt - wc0 !== 2)
         $display("FAIL ovf_run got %b:%0d exp 0:2",
                  fetch_hold, wr_cnt - wc0);
      else n_pass++;
      n_checks++;
      if (tb_mem[1022] !== DW'(32'hD0) || tb_mem[1023] !== DW'(32'hD1))
         $display("FAIL ovf_mem got %h:%h exp d0:d1",
                  tb_mem[1022], tb_mem[1023]);
      else n_pass++;
      nxt();
   endtask

   task automatic test_abort();
      grant(AW'(200));
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data  = DW'(32'hC0 + i);
         ld_last  = 1'b0;
         nxt();
      end
      load_req = 1'b0;
      ld_valid = 1'b1;
      ld_data  = DW'(32'hCF);
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b0 || ld_ready !== 1'b1)
         $display("FAIL abort_nowr got %b:%b exp 0:1", mem_en, ld_ready);
      else n_pass++;
      nxt();
      ld_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_o, load_err} !== 2'b11 || load_count !== 11'd2)
         $display("FAIL abort_restart got %b:%0d exp 11:2",
                  {cpu_rst_o, load_err}, load_count);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if ({fetch_hold, cpu_rst_o} !== 2'b00)
         $display("FAIL abort_run got %b exp 00", {fetch_hold, cpu_rst_o});
      else n_pass++;
      n_checks++;
      if (tb_mem[200] !== DW'(32'hC0) || tb_mem[201] !== DW'(32'hC1) ||
          tb_mem[202] === DW'(32'hCF))
         $display("FAIL abort_mem got %h:%h:%h exp c0:c1:-",
                  tb_mem[200], tb_mem[201], tb_mem[202]);
      else n_pass++;
      nxt();
   endtask

   task automatic test_reset_mid_load();
      grant(AW'(300));
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = DW'(32'hE0 + i);
         ld_last  = 1'b0;
         nxt();
      end
      ld_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      n_checks++;
      if (load_count !== 11'd3 || ld_ready !== 1'b1)
         $display("FAIL rstm_pre got %0d:%b exp 3:1", load_count, ld_ready);
      else n_pass++;
      nxt();
      rst      = 1'b0;
      load_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ld_ready, fetch_hold, cpu_rst_o, load_busy} !== 4'b0000)
         $display("FAIL rstm_flags got %b exp 0000",
                  {ld_ready, fetch_hold, cpu_rst_o, load_busy});
      else n_pass++;
      n_checks++;
      if (load_count !== 11'd0 || load_err !== 1'b0)
         $display("FAIL rstm_cnt got %0d:%b exp 0:0", load_count, load_err);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if (cpu_rst_o !== 1'b0 || fetch_hold !== 1'b0)
         $display("FAIL rstm_nopulse got %b:%b exp 0:0",
                  cpu_rst_o, fetch_hold);
      else n_pass++;
      nxt();
   endtask

   task automatic test_back_to_back();
      grant(AW'(500));
      ld_valid = 1'b1;
      ld_data  = DW'(32'hF0);
      ld_last  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== AW'(500))
         $display("FAIL b2b_wr got %b:%0d exp 1:500", mem_en, mem_addr);
      else n_pass++;
      nxt();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_rst_o !== 1'b1)
         $display("FAIL b2b_restart got %b exp 1", cpu_rst_o);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if ({fetch_hold, cpu_rst_o, load_busy} !== 3'b000 ||
          load_count !== 11'd1)
         $display("FAIL b2b_run got %b:%0d exp 000:1",
                  {fetch_hold, cpu_rst_o, load_busy}, load_count);
      else n_pass++;
      nxt();
      load_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fetch_hold !== 1'b1 || load_count !== 11'd0)
         $display("FAIL b2b_hold got %b:%0d exp 1:0",
                  fetch_hold, load_count);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if (ld_ready !== 1'b1 || mem_en !== 1'b0)
         $display("FAIL b2b_load got %b:%b exp 1:0", ld_ready, mem_en);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_o, load_err} !== 2'b11 || load_count !== 11'd0)
         $display("FAIL b2b_abort got %b:%0d exp 11:0",
                  {cpu_rst_o, load_err}, load_count);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if (fetch_hold !== 1'b0)
         $display("FAIL b2b_end got %b exp 0", fetch_hold);
      else n_pass++;
      nxt();
   endtask

   initial begin
      rst        = 1'b1;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      load_req   = 1'b0;
      ld_base    = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;
      test_reset();
      test_fetch();
      test_load_basic();
      test_throttle();
      test_overflow();
      test_abort();
      test_reset_mid_load();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single-port instruction memory and shares it between two requesters: the fetch stage (reads, one per cycle) and a program loader (burst writes, valid/ready).
- When a load is requested, it holds the fetch stage, lets any in-flight read retire, and grants the memory to the loader.
- After the image is written, it pulses a CPU restart so fetch begins again from address 0 with the new program.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DATA_W, 32, instruction word width.
- DEPTH, 1024, memory depth in words (= 2**ADDR_W).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch stage wants a read this cycle.
- fetch_addr  in  ADDR_W  fetch read word address.
- fetch_hold  out  1  stall to fetch stage (treat as stall_EX).
- cpu_rst_o  out  1  one-cycle restart pulse to fetch/pipeline.
- load_req  in  1  loader requests memory ownership; level, held for the whole burst.
- ld_base  in  ADDR_W  first write address; sampled on grant.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  marks final word; qualified by ld_valid.
- ld_ready  out  1  arbiter accepts a word this cycle.
- load_busy  out  1  high in every state except RUN.
- load_count  out  ADDR_W+1  words accepted in the current/last burst.
- load_err  out  1  sticky: overflow or aborted burst.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.

Behaviour:
- States: RUN, HOLD, LOAD, RESTART. Register all outputs except the mem_* mux.
- Reset (sync, any state, including mid-burst):
  - state = RUN.
  - fetch_hold, cpu_rst_o, ld_ready, load_busy, load_err = 0; load_count = 0.
  - Internal write pointer = 0.
- RUN:
  - mem_en = fetch_req, mem_we = 0, mem_addr = fetch_addr (combinational pass-through).
  - fetch_hold = 0.
  - If load_req = 1: next = HOLD; latch wptr = ld_base; clear load_count and load_err.
- HOLD (exactly 1 cycle):
  - fetch_hold = 1, mem_en = 0.
  - Lets the read issued in the last RUN cycle complete; fetch requests are ignored.
  - next = LOAD.
- LOAD:
  - fetch_hold = 1, ld_ready = 1.
  - On ld_valid & ld_ready:
    - Normal case: mem_en = 1, mem_we = 1, mem_addr = wptr, mem_wdata = ld_data; wptr += 1; load_count += 1.
    - Overflow: when the word would be written at wptr > DEPTH-1 (pointer past the top, no wrap), drop the write (mem_en = 0), set load_err, still increment load_count. ld_ready stays high so the loader can always finish.
  - ld_valid & ld_last → next = RESTART (the last word is written in that same cycle, unless it overflows).
  - load_req falls without last → abort: set load_err, next = RESTART, no write that cycle.
  - load_req and ld_valid & ld_last in the same cycle → treated as a normal completion.
- RESTART (1 cycle):
  - cpu_rst_o = 1, fetch_hold = 1, ld_ready = 0, mem_en = 0.
  - next = RUN.
  - load_req still high at this point → ignored until it is seen again in RUN; no back-to-back regrant without one RUN cycle.
- Latency:
  - load_req high in RUN → ld_ready high 2 cycles later.
  - ld_last accepted → cpu_rst_o on the next cycle → fetch resumes on the cycle after.
- load_count and load_err hold their values in RUN until the next grant.

Test Plan:
- Reset then fetch_req = 1, fetch_addr = 5,6,7 → mem_addr follows 5,6,7; mem_we = 0; fetch_hold = 0.
- load_req at cycle T, ld_base = 0, 4 words 0xA0..0xA3 with last on the 4th → HOLD at T+1; ld_ready at T+2; writes to addr 0..3; cpu_rst_o = 1 the cycle after the 4th write; load_count = 4; load_err = 0.
- Loader throttles ld_valid 1,0,1,0 → writes only on valid cycles; addresses contiguous; fetch_hold stays 1 throughout.
- ld_base = 1022, 4 words → addresses 1022 and 1023 written; 2 writes dropped; load_err = 1; load_count = 4; RESTART still occurs.
- load_req drops after 2 words with no last → load_err = 1; RESTART pulse; return to RUN; memory holds the 2 words.
- rst asserted in LOAD after 3 words → next cycle RUN; ld_ready = 0; fetch_hold = 0; load_count = 0; no cpu_rst_o pulse.
